// File: rtl/write_bank_drain_if.sv
// write_bank_drain_if: control, write-bank read port and packed output stream of the bank drain
interface write_bank_drain_if #(
  parameter int BANK_WIDTH = 10,
  parameter int MEM_BUFFER_DEPTH_BYTES = 512,
  parameter int OUT_BYTES = 8
);
  localparam int AW = $clog2(MEM_BUFFER_DEPTH_BYTES);
  localparam int SW = BANK_WIDTH > 1 ? $clog2(BANK_WIDTH) : 1;
  logic start;
  logic [AW:0] rows;
  logic busy;
  logic done;
  logic [AW-1:0] bank_address;
  logic [SW-1:0] bank_read_sel;
  logic [7:0] bank_data;
  logic [8*OUT_BYTES-1:0] out_data;
  logic out_valid;
  logic out_last;
  logic out_ready;
  modport master (
    input start, rows, bank_data, out_ready,
    output busy, done, bank_address, bank_read_sel, out_data, out_valid, out_last
  );
  modport slave (
    output start, rows, bank_data, out_ready,
    input busy, done, bank_address, bank_read_sel, out_data, out_valid, out_last
  );
endinterface

// File: rtl/write_bank_drain.sv
// write_bank_drain: walks a write bank row-major and packs returned bytes into OUT_BYTES-wide stream words
module write_bank_drain #(
  parameter int BANK_WIDTH = 10,
  parameter int MEM_BUFFER_DEPTH_BYTES = 512,
  parameter int OUT_BYTES = 8
) (
  input logic clk,
  input logic rst,
  write_bank_drain_if.master io
);
  localparam int AW = $clog2(MEM_BUFFER_DEPTH_BYTES);
  localparam int SW = BANK_WIDTH > 1 ? $clog2(BANK_WIDTH) : 1;
  localparam int CW = $clog2(OUT_BYTES + 1);
  localparam int DW = 8 * OUT_BYTES;
  localparam logic [SW-1:0] SEL_MAX = SW'(BANK_WIDTH - 1);
  localparam logic [AW:0] DEPTH = (AW + 1)'(MEM_BUFFER_DEPTH_BYTES);
  localparam logic [AW:0] ONE_ROW = (AW + 1)'(1);
  localparam logic [CW-1:0] FULL = CW'(OUT_BYTES);
  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} state_t;
  state_t state_q, state_d;
  logic [AW:0] rows_q, rows_d, rows_c;
  logic [AW-1:0] addr_q, addr_d, next_addr;
  logic [SW-1:0] sel_q, sel_d, next_sel;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] asm_q, asm_d, data_q, data_d;
  logic rd_q, rd_d, v1_q, v1_d;
  logic valid_q, valid_d, last_q, last_d, busy_q, busy_d, done_q, done_d;
  logic free, drained, move, issue, next_last;
  always_comb begin
    rows_c = io.rows > DEPTH ? DEPTH : io.rows;
    next_sel = sel_q == SEL_MAX ? '0 : sel_q + 1'b1;
    next_addr = sel_q == SEL_MAX ? addr_q + 1'b1 : addr_q;
    next_last = ({1'b0, next_addr} == rows_q - ONE_ROW) && next_sel == SEL_MAX;
    free = !valid_q || io.out_ready;
    // all reads issued and none outstanding: whatever sits in the assembly is the final word
    drained = state_q == FLUSH && !rd_q && !v1_q;
    move = free && (cnt_q == FULL || (drained && cnt_q != '0));
    cnt_d = move ? '0 : cnt_q + CW'(v1_q);
    asm_d = move ? '0 : asm_q;
    if (!move && v1_q) asm_d[8*cnt_q +: 8] = io.bank_data;
    // reads in flight after this edge are rd_q plus the new one, so the assembly can never overflow
    issue = state_q == DRAIN && int'(cnt_d) + int'(rd_q) < OUT_BYTES;
    state_d = state_q;
    rows_d = rows_q;
    addr_d = addr_q;
    sel_d = sel_q;
    rd_d = 1'b0;
    case (state_q)
      IDLE: if (io.start) begin
        rows_d = rows_c;
        if (rows_c == '0) state_d = DONE;
        else begin
          state_d = (SEL_MAX == '0 && rows_c == ONE_ROW) ? FLUSH : DRAIN;
          addr_d = '0;
          sel_d = '0;
          rd_d = 1'b1;
        end
      end
      DRAIN: if (issue) begin
        addr_d = next_addr;
        sel_d = next_sel;
        rd_d = 1'b1;
        if (next_last) state_d = FLUSH;
      end
      FLUSH: if (valid_q && io.out_ready && last_q) state_d = DONE;
      DONE: state_d = IDLE;
    endcase
    v1_d = rd_q;
    valid_d = move || (valid_q && !io.out_ready);
    last_d = move ? drained : last_q && valid_q && !io.out_ready;
    data_d = move ? asm_q : data_q;
    busy_d = state_d == DRAIN || state_d == FLUSH;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rows_q <= '0;
      addr_q <= '0;
      sel_q <= '0;
      cnt_q <= '0;
      asm_q <= '0;
      data_q <= '0;
      rd_q <= 1'b0;
      v1_q <= 1'b0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rows_q <= rows_d;
      addr_q <= addr_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
      asm_q <= asm_d;
      data_q <= data_d;
      rd_q <= rd_d;
      v1_q <= v1_d;
      valid_q <= valid_d;
      last_q <= last_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign io.busy = busy_q;
  assign io.done = done_q;
  assign io.bank_address = addr_q;
  assign io.bank_read_sel = sel_q;
  assign io.out_data = data_q;
  assign io.out_valid = valid_q;
  assign io.out_last = last_q;
endmodule

// File: tb/tb_write_bank_drain.sv
// tb_write_bank_drain: random-backpressure bench checking the drain against a byte-queue reference model
module tb_write_bank_drain;
  localparam int BW = 10;
  localparam int DEPTH = 512;
  localparam int OB = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  write_bank_drain_if #(.BANK_WIDTH(BW), .MEM_BUFFER_DEPTH_BYTES(DEPTH), .OUT_BYTES(OB)) io();
  write_bank_drain #(.BANK_WIDTH(BW), .MEM_BUFFER_DEPTH_BYTES(DEPTH), .OUT_BYTES(OB)) dut (
    .clk(clk),
    .rst(rst),
    .io(io)
  );
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int widx = 0;
  int ndone = 0;
  int acc_cyc = 0;
  int done_cyc = 0;
  int n;
  bit vseen = 0;
  bit mon_en = 0;
  bit rdy_rand = 0;
  bit pv = 0;
  bit pr = 0;
  bit pl = 0;
  logic [63:0] pd = '0;
  logic [63:0] exp_d[$];
  bit exp_l[$];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  // reference: the whole drain as a flat byte list chopped into zero-padded words
  task automatic build(input int r);
    byte unsigned b[$];
    int rc = r > DEPTH ? DEPTH : r;
    exp_d.delete();
    exp_l.delete();
    for (int a = 0; a < rc; a++)
      for (int s = 0; s < BW; s++) b.push_back(8'(a * 16 + s));
    for (int i = 0; i < b.size(); i += OB) begin
      logic [63:0] w = '0;
      for (int k = 0; k < OB; k++) if (i + k < b.size()) w[8*k +: 8] = b[i+k];
      exp_d.push_back(w);
      exp_l.push_back(i + OB >= b.size());
    end
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) io.bank_data <= 8'(int'(io.bank_address) * 16 + int'(io.bank_read_sel));
  initial begin
    io.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 io.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end
  always @(negedge clk) begin
    if (rst || !mon_en) pv = 0;
    else begin
      if (pv && !pr) begin
        chk("hold_valid", 64'(io.out_valid), 1);
        chk("hold_data", io.out_data, pd);
        chk("hold_last", 64'(io.out_last), 64'(pl));
      end
      if (io.out_valid) vseen = 1;
      if (io.out_valid && io.out_ready) begin
        if (widx < exp_d.size()) begin
          chk("word_data", io.out_data, exp_d[widx]);
          chk("word_last", 64'(io.out_last), 64'(exp_l[widx]));
        end else chk("extra_word", 64'(widx), 64'(exp_d.size()));
        if (io.out_last) acc_cyc = cyc;
        widx++;
      end
      if (io.done) begin
        ndone++;
        done_cyc = cyc;
      end
      pv = io.out_valid;
      pr = io.out_ready;
      pd = io.out_data;
      pl = io.out_last;
    end
  end
  task automatic run(input int r, input bit rnd, input bit poke);
    logic [8:0] a0 = io.bank_address;
    logic [3:0] s0 = io.bank_read_sel;
    int k = 0;
    bit got = 0;
    build(r);
    widx = 0;
    ndone = 0;
    vseen = 0;
    rdy_rand = rnd;
    @(posedge clk);
    #1 io.start = 1'b1;
    io.rows = 10'(r);
    @(posedge clk);
    #1 io.start = 1'b0;
    while (k < 30000 && !got) begin
      @(negedge clk);
      k++;
      got = io.done;
      if (k == 1) chk("busy_after_start", 64'(io.busy), 64'(r > 0));
      if (poke && k == 50) io.start = 1'b1;
      if (poke && k == 51) io.start = 1'b0;
    end
    chk("done_seen", 64'(got), 1);
    repeat (3) @(negedge clk);
    chk("word_count", 64'(widx), 64'(exp_d.size()));
    chk("done_count", 64'(ndone), 1);
    chk("idle_busy", 64'(io.busy), 0);
    if (r == 0) begin
      chk("r0_latency", 64'(k), 1);
      chk("r0_addr", 64'(io.bank_address), 64'(a0));
      chk("r0_sel", 64'(io.bank_read_sel), 64'(s0));
      chk("r0_valid", 64'(vseen), 0);
    end else chk("done_latency", 64'(done_cyc - acc_cyc), 1);
    if (!rnd && r > 0) chk("throughput", 64'(k <= exp_d.size() * (OB + 2) + 8), 1);
  endtask
  initial begin
    io.start = 1'b0;
    io.rows = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(io.busy), 0);
    chk("rst_done", 64'(io.done), 0);
    chk("rst_valid", 64'(io.out_valid), 0);
    chk("rst_last", 64'(io.out_last), 0);
    chk("rst_data", io.out_data, 0);
    chk("rst_addr", 64'(io.bank_address), 0);
    chk("rst_sel", 64'(io.bank_read_sel), 0);
    rst = 1'b0;
    mon_en = 1;
    run(1, 0, 0);
    run(4, 1, 0);
    run(0, 0, 0);
    for (int i = 0; i < 3; i++) run($urandom_range(1, 20), 1, 0);
    run(512, 0, 1);
    chk("full_last_addr", 64'(io.bank_address), 511);
    chk("full_last_sel", 64'(io.bank_read_sel), 9);
    run(700, 0, 0);
    mon_en = 0;
    rdy_rand = 1;
    @(posedge clk);
    #1 io.start = 1'b1;
    io.rows = 10'd8;
    @(posedge clk);
    #1 io.start = 1'b0;
    n = 0;
    while (n < 500 && !io.out_valid) begin
      @(negedge clk);
      n++;
    end
    chk("mid_valid_seen", 64'(io.out_valid), 1);
    rst = 1'b1;
    #1;
    chk("async_valid", 64'(io.out_valid), 0);
    chk("async_busy", 64'(io.busy), 0);
    chk("async_addr", 64'(io.bank_address), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rdy_rand = 0;
    mon_en = 1;
    run(1, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
